// File: rtl/spi_fl_pkg.sv
// rtl/spi_fl_pkg.sv - shared types and constants for the SPI flash master
package spi_fl_pkg;
    localparam int CMD_W    = 8;
    localparam int NBITS_W  = 7;
    localparam int DUMMY_W  = 5;
    localparam int CT_ADDR  = 0;
    localparam int CT_WRITE = 1;
    localparam int CT_READ  = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
`ifdef SPI_FL_DUMMY_EN
        S_DUMMY,
`endif
        S_WRITE,
        S_READ,
        S_DONE
    } state_e;
endpackage

// File: rtl/spi_master_fl_gen_if.sv
// rtl/spi_master_fl_gen_if.sv - request/response bus of the SPI flash master (ndummy only with SPI_FL_DUMMY_EN)
interface spi_master_fl_gen_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 24
) ();
    import spi_fl_pkg::*;

    logic [DATA_W-1:0]  data_in;
    logic [ADDR_W-1:0]  address;
    logic [CMD_W-1:0]   command;
    logic [2:0]         commtype;
    logic [NBITS_W-1:0] nmiso_bits;
    logic               validflag;
`ifdef SPI_FL_DUMMY_EN
    logic [DUMMY_W-1:0] ndummy;
`endif
    logic [DATA_W-1:0]  data_out;
    logic               validflag_out;
    logic               tready;

    modport master (
        output data_in, address, command, commtype, nmiso_bits, validflag,
`ifdef SPI_FL_DUMMY_EN
        output ndummy,
`endif
        input  data_out, validflag_out, tready
    );

    modport slave (
        input  data_in, address, command, commtype, nmiso_bits, validflag,
`ifdef SPI_FL_DUMMY_EN
        input  ndummy,
`endif
        output data_out, validflag_out, tready
    );
endinterface

// File: rtl/spi_fl_bit_timer.sv
// rtl/spi_fl_bit_timer.sv - SCLK generator: CLK_DIV cycles low then CLK_DIV high per bit, with edge strobes
module spi_fl_bit_timer #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic sclk,
    output logic rise,
    output logic fall,
    output logic bit_done
);
    localparam int CNT_W = $clog2(2 * CLK_DIV);
    localparam logic [CNT_W-1:0] RISE_AT   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HIGH_FROM = CNT_W'(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST      = CNT_W'(2 * CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;

    always_comb begin
        cnt_d  = '0;
        sclk_d = 1'b0;
        if (run) begin
            cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
            sclk_d = (cnt_d >= HIGH_FROM);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    // Strobes mark the clk edge that moves sclk high (rise) or low (fall)
    assign rise     = run && (cnt_q == RISE_AT);
    assign fall     = run && (cnt_q == LAST);
    assign bit_done = fall;
    assign sclk     = sclk_q;
endmodule

// File: rtl/spi_master_fl_gen.sv
// rtl/spi_master_fl_gen.sv - parametrised SPI flash master (CMD/ADDR/WRITE/READ; DUMMY phase with SPI_FL_DUMMY_EN)
module spi_master_fl_gen
    import spi_fl_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 24,
    parameter int CLK_DIV = 2
) (
    input  logic                clk,
    input  logic                rst,
    spi_master_fl_gen_if.slave  bus,
    output logic                ss,
    output logic                sclk,
    output logic                mosi,
    input  logic                miso
);
    localparam int WIDE = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
    localparam int SH_W = (WIDE > CMD_W) ? WIDE : CMD_W;
    localparam int LEN_W = 8;

    state_e            state_q, state_d, nxt;
    state_e            after_cmd, after_addr, after_dum, after_write;
    logic [SH_W-1:0]   sh_q, sh_d;
    logic [LEN_W-1:0]  len_q, len_d, rdlen_q, rdlen_d;
    logic [DATA_W-1:0] rx_q, rx_d, dout_q, dout_d, din_q, din_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              a_q, a_d, w_q, w_d;
`ifdef SPI_FL_DUMMY_EN
    logic [DUMMY_W-1:0] dum_q, dum_d;
`endif
    logic              idle_like, rise, fall, bit_done;

    function automatic logic [SH_W-1:0] left_align(input logic [SH_W-1:0] v, input int w);
        left_align = v << (SH_W - w);
    endfunction

    assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);

    spi_fl_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .run      (!idle_like),
        .sclk     (sclk),
        .rise     (rise),
        .fall     (fall),
        .bit_done (bit_done)
    );

    // Phase successor chain; disabled phases fall straight through
    always_comb begin
        after_write = (rdlen_q != '0) ? S_READ : S_DONE;
        after_dum   = w_q ? S_WRITE : after_write;
`ifdef SPI_FL_DUMMY_EN
        after_addr  = (dum_q != '0) ? S_DUMMY : after_dum;
`else
        after_addr  = after_dum;
`endif
        after_cmd   = a_q ? S_ADDR : after_addr;
        case (state_q)
            S_CMD:   nxt = after_cmd;
            S_ADDR:  nxt = after_addr;
`ifdef SPI_FL_DUMMY_EN
            S_DUMMY: nxt = after_dum;
`endif
            S_WRITE: nxt = after_write;
            default: nxt = S_DONE;
        endcase
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        len_d   = len_q;
        rdlen_d = rdlen_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        din_d   = din_q;
        addr_d  = addr_q;
        a_d     = a_q;
        w_d     = w_q;
`ifdef SPI_FL_DUMMY_EN
        dum_d   = dum_q;
`endif
        if (idle_like) begin
            state_d = S_IDLE;
            if (bus.validflag) begin
                state_d = S_CMD;
                sh_d    = left_align(SH_W'(bus.command), CMD_W);
                len_d   = LEN_W'(CMD_W - 1);
                rx_d    = '0;
                din_d   = bus.data_in;
                addr_d  = bus.address;
                a_d     = bus.commtype[CT_ADDR];
                w_d     = bus.commtype[CT_WRITE];
`ifdef SPI_FL_DUMMY_EN
                dum_d   = bus.ndummy;
`endif
                if (!bus.commtype[CT_READ])
                    rdlen_d = '0;
                else if (int'(bus.nmiso_bits) > DATA_W)
                    rdlen_d = LEN_W'(DATA_W);
                else
                    rdlen_d = LEN_W'(bus.nmiso_bits);
            end
        end else begin
            if (state_q == S_READ && rise)
                rx_d = {rx_q[DATA_W-2:0], miso};
            if (fall)
                sh_d = sh_q << 1;
            if (bit_done) begin
                if (len_q != '0) begin
                    len_d = len_q - LEN_W'(1);
                end else begin
                    state_d = nxt;
                    case (nxt)
                        S_ADDR: begin
                            sh_d  = left_align(SH_W'(addr_q), ADDR_W);
                            len_d = LEN_W'(ADDR_W - 1);
                        end
`ifdef SPI_FL_DUMMY_EN
                        S_DUMMY: begin
                            sh_d  = '0;
                            len_d = LEN_W'(dum_q) - LEN_W'(1);
                        end
`endif
                        S_WRITE: begin
                            sh_d  = left_align(SH_W'(din_q), DATA_W);
                            len_d = LEN_W'(DATA_W - 1);
                        end
                        S_READ: begin
                            sh_d  = '0;
                            len_d = rdlen_q - LEN_W'(1);
                        end
                        default: begin
                            sh_d = '0;
                            if (rdlen_q != '0)
                                dout_d = rx_q;
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            len_q   <= '0;
            rdlen_q <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            din_q   <= '0;
            addr_q  <= '0;
            a_q     <= 1'b0;
            w_q     <= 1'b0;
`ifdef SPI_FL_DUMMY_EN
            dum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            len_q   <= len_d;
            rdlen_q <= rdlen_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            din_q   <= din_d;
            addr_q  <= addr_d;
            a_q     <= a_d;
            w_q     <= w_d;
`ifdef SPI_FL_DUMMY_EN
            dum_q   <= dum_d;
`endif
        end
    end

    assign ss                = idle_like;
    assign mosi              = sh_q[SH_W-1];
    assign bus.tready        = idle_like;
    assign bus.validflag_out = (state_q == S_DONE);
    assign bus.data_out      = dout_q;
endmodule
